// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage rv32i pipeline: it merges the I/D cache
// handshakes, load-use stalls and EX redirects into PC and pipe-register controls.
module pipeline_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             hazard_stall,
  input  logic             ex_br_flush,
  output logic             imem_read,
  output logic             dmem_enable,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             id_ex_load,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  logic imem_done_q, imem_done_d;
  logic dmem_done_q, dmem_done_d;
  logic lu_done_q, lu_done_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic imem_ok, dmem_ok, advance, lu_act, dresp_v;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // The done flags encode the RUN/WAIT state: WAIT whenever either is set.
  always_comb begin
    dresp_v = dmem_req & dmem_resp;
    imem_ok = imem_resp | imem_done_q;
    dmem_ok = ~dmem_req | dmem_resp | dmem_done_q;
    advance = imem_ok & dmem_ok;
    lu_act  = hazard_stall & ~lu_done_q;

    imem_done_d   = imem_done_q;
    dmem_done_d   = dmem_done_q;
    lu_done_d     = lu_done_q;
    stall_d       = stall_q;
    bubble_d      = bubble_q;
    flush_d       = flush_q;
    imem_read     = ~imem_done_q;
    dmem_enable   = dmem_req & ~dmem_done_q;
    pc_load       = 1'b0;
    if_id_load    = 1'b0;
    id_ex_load    = 1'b0;
    ex_mem_load   = 1'b0;
    mem_wb_load   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;

    if (!advance) begin
      imem_done_d = imem_done_q | imem_resp;
      dmem_done_d = dmem_done_q | dresp_v;
      stall_d     = sat_inc(stall_q);
    end else begin
      imem_done_d = 1'b0;
      dmem_done_d = 1'b0;
      if (lu_act) begin
        // Redirect is ignored here: the branch resolved on stale operands.
        ex_mem_load   = 1'b1;
        ex_mem_bubble = 1'b1;
        mem_wb_load   = 1'b1;
        lu_done_d     = 1'b1;
        bubble_d      = sat_inc(bubble_q);
      end else begin
        pc_load     = 1'b1;
        if_id_load  = 1'b1;
        id_ex_load  = 1'b1;
        ex_mem_load = 1'b1;
        mem_wb_load = 1'b1;
        lu_done_d   = 1'b0;
        if (ex_br_flush) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_d     = sat_inc(flush_q);
        end
      end
    end

    if (!rst) begin
      imem_read     = 1'b0;
      dmem_enable   = 1'b0;
      pc_load       = 1'b0;
      if_id_load    = 1'b0;
      id_ex_load    = 1'b0;
      ex_mem_load   = 1'b0;
      mem_wb_load   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
      lu_done_q   <= 1'b0;
      stall_q     <= '0;
      bubble_q    <= '0;
      flush_q     <= '0;
    end else begin
      imem_done_q <= imem_done_d;
      dmem_done_q <= dmem_done_d;
      lu_done_q   <= lu_done_d;
      stall_q     <= stall_d;
      bubble_q    <= bubble_d;
      flush_q     <= flush_d;
    end
  end

  assign stall_count  = stall_q;
  assign bubble_count = bubble_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: the driver queues hand-computed
// expectations per cycle, and a negedge monitor pops and compares them.
module tb_pipeline_controller;
  localparam int unsigned CNT_W = 4;

  logic clk, rst;
  logic imem_resp, dmem_req, dmem_resp, hazard_stall, ex_br_flush;
  logic imem_read, dmem_enable, pc_load, if_id_load, id_ex_load, ex_mem_load;
  logic mem_wb_load, if_id_flush, id_ex_flush, ex_mem_bubble;
  logic [CNT_W-1:0] stall_count, bubble_count, flush_count;

  pipeline_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req(dmem_req),
    .dmem_resp(dmem_resp), .hazard_stall(hazard_stall), .ex_br_flush(ex_br_flush),
    .imem_read(imem_read), .dmem_enable(dmem_enable), .pc_load(pc_load),
    .if_id_load(if_id_load), .id_ex_load(id_ex_load), .ex_mem_load(ex_mem_load),
    .mem_wb_load(mem_wb_load), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_bubble(ex_mem_bubble), .stall_count(stall_count),
    .bubble_count(bubble_count), .flush_count(flush_count)
  );

  // ctl order: imem_read dmem_enable | pc if_id id_ex ex_mem mem_wb | if_id_fl id_ex_fl bubble
  typedef struct {
    logic [9:0] ctl;
    int         stall;
    int         bub;
    int         fl;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] act_ctl();
    return {imem_read, dmem_enable, pc_load, if_id_load, id_ex_load, ex_mem_load,
            mem_wb_load, if_id_flush, id_ex_flush, ex_mem_bubble};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: outputs are valid every cycle, so compare once per queued entry.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".ctl"}, int'(act_ctl()), int'(e.ctl));
      chk({e.name, ".stall"}, int'(stall_count), e.stall);
      chk({e.name, ".bubble"}, int'(bubble_count), e.bub);
      chk({e.name, ".flush"}, int'(flush_count), e.fl);
    end
  end

  task automatic cyc(input string name, input logic r, input logic ir, input logic dq,
                     input logic dr, input logic hz, input logic br,
                     input logic [9:0] ctl, input int st, input int bu, input int fl);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; imem_resp = ir; dmem_req = dq; dmem_resp = dr;
    hazard_stall = hz; ex_br_flush = br;
    e.ctl = ctl; e.stall = st; e.bub = bu; e.fl = fl; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input string name);
    cyc({name, ".rst0"}, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'b0000000000, 0, 0, 0);
    cyc({name, ".rst1"}, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'b0000000000, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    hazard_stall = 1'b0; ex_br_flush = 1'b0;

    // Reset with responses pulsing, then a plain fetch after 2 idle cycles.
    do_reset("t1");
    cyc("t2.c1", 1, 0, 0, 0, 0, 0, 10'b1000000000, 0, 0, 0);
    cyc("t2.c2", 1, 0, 0, 0, 0, 0, 10'b1000000000, 1, 0, 0);
    cyc("t2.c3", 1, 1, 0, 0, 0, 0, 10'b1011111000, 2, 0, 0);
    cyc("t2.c4", 1, 0, 0, 0, 0, 0, 10'b1000000000, 2, 0, 0);

    // I-response latched early, D-response three cycles later.
    do_reset("t3");
    cyc("t3.c1", 1, 1, 1, 0, 0, 0, 10'b1100000000, 0, 0, 0);
    cyc("t3.c2", 1, 0, 1, 0, 0, 0, 10'b0100000000, 1, 0, 0);
    cyc("t3.c3", 1, 0, 1, 0, 0, 0, 10'b0100000000, 2, 0, 0);
    cyc("t3.c4", 1, 0, 1, 1, 0, 0, 10'b0111111000, 3, 0, 0);
    cyc("t3.c5", 1, 0, 0, 0, 0, 0, 10'b1000000000, 3, 0, 0);

    // Held load-use hazard inserts exactly one bubble.
    do_reset("t4");
    cyc("t4.c1", 1, 1, 0, 0, 1, 0, 10'b1000011001, 0, 0, 0);
    cyc("t4.c2", 1, 1, 0, 0, 1, 0, 10'b1011111000, 0, 1, 0);
    cyc("t4.c3", 1, 0, 0, 0, 0, 0, 10'b1000000000, 0, 1, 0);

    // Redirect ignored during the bubble, applied on the next advance.
    do_reset("t5");
    cyc("t5.c1", 1, 1, 0, 0, 1, 1, 10'b1000011001, 0, 0, 0);
    cyc("t5.c2", 1, 1, 0, 0, 1, 1, 10'b1011111110, 0, 1, 0);
    cyc("t5.c3", 1, 0, 0, 0, 0, 0, 10'b1000000000, 0, 1, 1);

    // Simultaneous responses advance at once; stray dmem_resp sets nothing.
    do_reset("t7");
    cyc("t7.c1", 1, 1, 1, 1, 0, 0, 10'b1111111000, 0, 0, 0);
    cyc("t7.c2", 1, 0, 0, 1, 0, 0, 10'b1000000000, 0, 0, 0);
    cyc("t7.c3", 1, 1, 1, 0, 0, 0, 10'b1100000000, 1, 0, 0);
    cyc("t7.c4", 1, 0, 1, 0, 0, 0, 10'b0100000000, 2, 0, 0);

    // Saturation of stall_count at 15, then async reset mid-WAIT.
    do_reset("t6");
    for (int k = 1; k <= 20; k++)
      cyc($sformatf("t6.idle%0d", k), 1, 0, 0, 0, 0, 0, 10'b1000000000,
          (k - 1 > 15) ? 15 : k - 1, 0, 0);
    cyc("t6.wait0", 1, 1, 1, 0, 0, 0, 10'b1100000000, 15, 0, 0);
    cyc("t6.wait1", 1, 0, 1, 0, 0, 0, 10'b0100000000, 15, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6.async.ctl", int'(act_ctl()), 0);
    chk("t6.async.stall", int'(stall_count), 0);
    chk("t6.async.bubble", int'(bubble_count), 0);
    chk("t6.async.flush", int'(flush_count), 0);
    cyc("t6.after", 1, 0, 1, 0, 0, 0, 10'b1100000000, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
Central stall/flush sequencer for the 5-stage rv32i pipeline. It takes the forwarding unit's load-use stall, the EX-stage branch/jump redirect and the split I/D cache handshakes, and drives the PC and pipeline-register load and flush controls. It latches cache responses that arrive while the other port is still busy, so each fetch and each data access completes exactly once. It also keeps saturating performance counters.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
imem_resp  input  1  I-cache response pulse, one cycle
dmem_req  input  1  MEM stage holds a load/store
dmem_resp  input  1  D-cache response pulse, one cycle
hazard_stall  input  1  load-use hazard from forwarding unit
ex_br_flush  input  1  EX resolved a taken branch/jump (redirect)
imem_read  output  1  fetch request to I-cache
dmem_enable  output  1  qualifies datapath dmem_read/dmem_write
pc_load  output  1  load PC
if_id_load  output  1  load IF/ID
id_ex_load  output  1  load ID/EX
ex_mem_load  output  1  load EX/MEM
mem_wb_load  output  1  load MEM/WB
if_id_flush  output  1  IF/ID loads NOP
id_ex_flush  output  1  ID/EX loads NOP
ex_mem_bubble  output  1  EX/MEM loads NOP
stall_count  output  CNT_W  cycles with no advance
bubble_count  output  CNT_W  load-use bubbles inserted
flush_count  output  CNT_W  redirects applied

Behaviour:
- State registers: imem_done, dmem_done, lu_done (1 bit each), plus three counters. All clear on rst low, asynchronously.
- While rst is low, every output is 0.
- imem_ok = imem_resp | imem_done.
- dmem_ok = ~dmem_req | dmem_resp | dmem_done.
- advance = imem_ok & dmem_ok.
- Request gating:
  - imem_read = ~imem_done, out of reset.
  - dmem_enable = dmem_req & ~dmem_done.
  - Once a response is latched, that port does not re-issue.
- FSM, derived from the done flags: RUN (both flags 0) and WAIT (either flag 1).
  - RUN -> WAIT: exactly one of imem_resp or dmem_resp (with dmem_req) arrives and advance=0. Set the matching done flag.
  - WAIT -> RUN: advance=1. Clear imem_done and dmem_done on the same edge.
  - WAIT -> WAIT: second response still pending.
- advance=0: all loads 0, all flush/bubble 0, stall_count += 1 (saturating).
- advance=1 with lu_act = hazard_stall & ~lu_done:
  - pc_load, if_id_load, id_ex_load = 0.
  - ex_mem_load = 1, ex_mem_bubble = 1, mem_wb_load = 1.
  - Set lu_done; bubble_count += 1.
  - ex_br_flush is ignored this cycle, because the branch operands are stale.
- advance=1, ~lu_act:
  - All five loads = 1; clear lu_done.
  - If ex_br_flush: if_id_flush = 1, id_ex_flush = 1, flush_count += 1.
- lu_done suppresses the re-assertion of hazard_stall on the next advance, while the load sits in WB and the WB forward resolves it. Exactly one bubble is inserted per load-use.
- lu_done holds across non-advance cycles and clears only on a normal advance.
- Simultaneous imem_resp and dmem_resp in the same cycle: advance immediately, no flag is set.
- dmem_resp without dmem_req: ignored, no flag.
- Counters saturate at all-ones and never wrap.
- Latency: all control outputs are combinational from the state and the current inputs. Flags and counters update at the same clk edge.
- Reset mid-WAIT drops the latched responses. The datapath refetches the current PC after reset.

Test Plan:
1. Hold rst low; pulse imem_resp and dmem_resp -> all outputs 0, counters 0. Release rst -> imem_read=1, dmem_enable=0, loads 0 until the first response.
2. dmem_req=0; imem_resp at cycle 3 after reset -> advance (all loads 1) only in cycle 3; stall_count=2.
3. dmem_req=1; imem_resp at cycle 1, dmem_resp at cycle 4 -> imem_read=0 in cycles 2-4; loads 1 only in cycle 4; imem_done clears after cycle 4; stall_count=3.
4. hazard_stall=1 held for 2 advances, responses immediate:
   - First advance: pc/if_id/id_ex load 0, ex_mem_bubble=1, mem_wb_load=1.
   - Second advance: all loads 1.
   - bubble_count=1.
5. hazard_stall=1 and ex_br_flush=1 on the same advance -> bubble only, no flush, flush_count=0. Next advance with ex_br_flush=1 -> if_id_flush=1, id_ex_flush=1, flush_count=1.
6. Force stall_count to all-ones with CNT_W=4 and stall 20 cycles -> stays at 15. Assert rst low mid-WAIT with imem_done=1 -> flag and counters 0 asynchronously, with no clk edge needed.
